// File: rtl/toggle_rx.sv
// Toggle-link receiver: synchronizes a toggle level, emits one pulse per
// transition, counts events and runs an armable missing-toggle watchdog.
module toggle_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8,
   parameter int TIMEOUT     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             t_in,
   input  logic             arm,
   input  logic             clr_cnt,
   output logic             evt_pulse,
   output logic             level,
   output logic [CNT_W-1:0] count,
   output logic             ovf,
   output logic             busy,
   output logic             timeout
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      EXPIRED
   } state_t;

   localparam logic [15:0] RELOAD = 16'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [SYNC_STAGES-1:0] sync;
   logic                   hist;

   state_t     state, state_nxt;
   logic [15:0] timer, timer_nxt;
   logic        timeout_nxt;

   logic [CNT_W-1:0] count_nxt;
   logic             ovf_nxt;

   assign level = sync[SYNC_STAGES-1];
   assign busy  = (state == WAIT);

   // chain resets to 0 to match the transmitter's q reset value
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync      <= '0;
         hist      <= 1'b0;
         evt_pulse <= 1'b0;
      end else begin
         sync      <= {sync[SYNC_STAGES-2:0], t_in};
         hist      <= level;
         evt_pulse <= level ^ hist;
      end
   end

   always_comb begin
      count_nxt = count;
      ovf_nxt   = ovf;
      if (clr_cnt) begin
         count_nxt = evt_pulse ? CNT_W'(1) : '0;
         ovf_nxt   = 1'b0;
      end else if (evt_pulse) begin
         if (count == CNT_MAX) begin
            ovf_nxt = 1'b1;
         end else begin
            count_nxt = count + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         count <= count_nxt;
         ovf   <= ovf_nxt;
      end
   end

   // an event in WAIT beats both a re-arm and a same-cycle expiry
   always_comb begin
      state_nxt   = state;
      timer_nxt   = timer;
      timeout_nxt = timeout;
      case (state)
         IDLE: begin
            if (arm) begin
               state_nxt   = WAIT;
               timer_nxt   = RELOAD;
               timeout_nxt = 1'b0;
            end
         end
         WAIT: begin
            if (evt_pulse) begin
               state_nxt = IDLE;
            end else if (arm) begin
               timer_nxt = RELOAD;
            end else if (timer == 16'd0) begin
               state_nxt   = EXPIRED;
               timeout_nxt = 1'b1;
            end else begin
               timer_nxt = timer - 16'd1;
            end
         end
         EXPIRED: begin
            if (arm) begin
               state_nxt   = WAIT;
               timer_nxt   = RELOAD;
               timeout_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt   = IDLE;
            timer_nxt   = 16'd0;
            timeout_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         timer   <= 16'd0;
         timeout <= 1'b0;
      end else begin
         state   <= state_nxt;
         timer   <= timer_nxt;
         timeout <= timeout_nxt;
      end
   end

endmodule

// File: tb/tb_toggle_rx.sv
// Randomized and directed bench for toggle_rx against a sample-history
// reference model.
module tb_toggle_rx;

   localparam int S  = 2;
   localparam int CW = 8;
   localparam int TO = 16;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          t_in = 1'b0;
   logic          arm = 1'b0;
   logic          clr_cnt = 1'b0;
   logic          evt_pulse;
   logic          level;
   logic [CW-1:0] count;
   logic          ovf;
   logic          busy;
   logic          timeout;

   int nchk = 0;
   int nerr = 0;

   toggle_rx #(
      .SYNC_STAGES(S),
      .CNT_W(CW),
      .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .t_in(t_in),
      .arm(arm),
      .clr_cnt(clr_cnt),
      .evt_pulse(evt_pulse),
      .level(level),
      .count(count),
      .ovf(ovf),
      .busy(busy),
      .timeout(timeout)
   );

   always #5 clk = ~clk;

   // reference: t_in as sampled on every edge since reset release
   bit q[$];
   int m_cnt;
   bit m_ovf;
   bit m_wait;
   bit m_exp;
   int m_arm_n;

   function automatic bit at(int i);
      return (i < 0) ? 1'b0 : q[i];
   endfunction

   function automatic bit exp_level();
      return at(q.size() - S);
   endfunction

   function automatic bit exp_pulse();
      int m = q.size();
      return at(m - 1 - S) != at(m - 2 - S);
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
         m_cnt   = 0;
         m_ovf   = 0;
         m_wait  = 0;
         m_exp   = 0;
         m_arm_n = 0;
      end else begin
         int  n;
         bit  ev;
         n  = q.size();
         ev = exp_pulse();
         if (clr_cnt) begin
            m_cnt = ev ? 1 : 0;
            m_ovf = 0;
         end else if (ev) begin
            if (m_cnt == CMAX) m_ovf = 1;
            else m_cnt = m_cnt + 1;
         end
         if (m_wait) begin
            if (ev) m_wait = 0;
            else if (arm) m_arm_n = n;
            else if (n - m_arm_n >= TO) begin
               m_wait = 0;
               m_exp  = 1;
            end
         end else if (arm) begin
            m_wait  = 1;
            m_exp   = 0;
            m_arm_n = n;
         end
         q.push_back(t_in);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                  $time);
      end
   endtask

   task automatic check_all();
      chk("evt_pulse", 32'(evt_pulse), 32'(exp_pulse()));
      chk("level", 32'(level), 32'(exp_level()));
      chk("count", 32'(count), 32'(m_cnt));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("busy", 32'(busy), 32'(m_wait));
      chk("timeout", 32'(timeout), 32'(m_exp));
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      cyc();
      arm = 1'b0;
   endtask

   task automatic zero_outs(input string tag);
      chk({tag, "_pulse"}, 32'(evt_pulse), 32'd0);
      chk({tag, "_level"}, 32'(level), 32'd0);
      chk({tag, "_count"}, 32'(count), 32'd0);
      chk({tag, "_ovf"}, 32'(ovf), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_tmo"}, 32'(timeout), 32'd0);
   endtask

   task automatic mid_reset(input bit settle);
      clr_cnt = 1'b1;
      cyc();
      clr_cnt = 1'b0;
      run(4);
      for (int i = 0; i < 5; i++) begin
         t_in = ~t_in;
         run(2);
      end
      run(4);
      chk("pre_rst_count", 32'(count), 32'd5);
      pulse_arm();
      chk("pre_rst_busy", 32'(busy), 32'd1);
      t_in = ~t_in;
      cyc();
      rst = 1'b0;
      #1;
      zero_outs("rst_mid");
      t_in = settle;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      run(6);
      chk("post_rst_count", 32'(count), settle ? 32'd1 : 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      #1;
      zero_outs("rst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      run(2);

      // single rise: pulse three edges after the change
      t_in = 1'b1;
      run(6);
      chk("first_count", 32'(count), 32'd1);
      chk("first_level", 32'(level), 32'd1);

      for (int i = 0; i < 4; i++) begin
         t_in = ~t_in;
         run(2);
      end
      run(4);
      chk("four_count", 32'(count), 32'd5);
      chk("four_level", 32'(level), 32'd1);

      // back-to-back toggles up to saturation, then clear with an event
      for (int i = 0; i < CMAX + 4; i++) begin
         t_in = ~t_in;
         cyc();
      end
      run(3);
      chk("sat_count", 32'(count), 32'(CMAX));
      chk("sat_ovf", 32'(ovf), 32'd1);
      t_in = ~t_in;
      run(3);
      clr_cnt = 1'b1;
      cyc();
      clr_cnt = 1'b0;
      chk("clr_ev_count", 32'(count), 32'd1);
      chk("clr_ev_ovf", 32'(ovf), 32'd0);
      run(3);

      // unanswered arm: expiry on cycle TO+1
      pulse_arm();
      run(TO - 1);
      chk("win_busy", 32'(busy), 32'd1);
      cyc();
      chk("exp_tmo", 32'(timeout), 32'd1);
      chk("exp_busy", 32'(busy), 32'd0);
      run(3);
      pulse_arm();
      chk("rearm_tmo", 32'(timeout), 32'd0);
      chk("rearm_busy", 32'(busy), 32'd1);
      run(TO + 4);

      // event lands on the final window cycle
      pulse_arm();
      run(TO - 4);
      t_in = ~t_in;
      run(6);
      chk("edge_win_tmo", 32'(timeout), 32'd0);
      chk("edge_win_busy", 32'(busy), 32'd0);

      // arm coincident with the event
      pulse_arm();
      cyc();
      t_in = ~t_in;
      run(3);
      pulse_arm();
      chk("ev_arm_busy", 32'(busy), 32'd0);
      run(3);

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) t_in = ~t_in;
         arm     = ($urandom_range(0, 29) == 0);
         clr_cnt = ($urandom_range(0, 49) == 0);
         cyc();
      end
      arm = 1'b0;
      clr_cnt = 1'b0;
      run(TO + 4);

      t_in = 1'b0;
      run(4);
      mid_reset(1'b1);
      mid_reset(1'b0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
